dp_microsequencer: RTL and testbench

//  Programmable replacement for the hard-wired controller of the register-file dedicated processor.

---
 rtl/dp_seq_pkg.sv | 51 +++++
 rtl/dp_seq_prog_mem.sv | 26 ++
 rtl/dp_microsequencer.sv | 127 ++++++++++++
 tb/tb_dp_microsequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_seq_pkg.sv
// Shared types and field layout for the dp_microsequencer program format.
package dp_seq_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int PC_W       = $clog2(PROG_DEPTH);
    localparam int INSTR_W    = 16 + PC_W;

    localparam int OP_W       = 4;
    localparam int REG_W      = 4;
    localparam int OP_LSB     = INSTR_W - 4;
    localparam int WADDR_LSB  = INSTR_W - 8;
    localparam int RADDR1_LSB = INSTR_W - 12;
    localparam int RADDR2_LSB = INSTR_W - 16;
    localparam int TARGET_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_MOVK = 4'h2,
        OP_OUT  = 4'h3,
        OP_BLE  = 4'h4,
        OP_JMP  = 4'h5,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] waddr;
        logic [REG_W-1:0] raddr1;
        logic [REG_W-1:0] raddr2;
        logic [PC_W-1:0]  target;
    } decode_t;

    // Unknown opcodes are kept as raw bits so they fall through to NOP behaviour.
    function automatic decode_t decode_instr(input logic [INSTR_W-1:0] word);
        decode_t d;
        d.op     = word[OP_LSB     +: OP_W];
        d.waddr  = word[WADDR_LSB  +: REG_W];
        d.raddr1 = word[RADDR1_LSB +: REG_W];
        d.raddr2 = word[RADDR2_LSB +: REG_W];
        d.target = word[TARGET_LSB +: PC_W];
        return d;
    endfunction

endpackage

// File: rtl/dp_seq_prog_mem.sv
// Program store for the microsequencer: one write port, one synchronous read port.
module dp_seq_prog_mem
    import dp_seq_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [PC_W-1:0]    waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [PROG_DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    // Read returns the old word on a same-cycle write to the same address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dp_microsequencer.sv
// Programmable controller driving the register-file datapath control bus.
// Optional single-step hold in FETCH is enabled by defining SEQ_SINGLE_STEP_EN.
module dp_microsequencer
    import dp_seq_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic               prog_we_i,
    input  logic [PC_W-1:0]    prog_addr_i,
    input  logic [INSTR_W-1:0] prog_data_i,
    input  logic               le_i,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step_mode_i,
    input  logic               step_i,
`endif
    output logic               MuxSel_o,
    output logic [3:0]         raddr1_o,
    output logic [3:0]         raddr2_o,
    output logic [3:0]         waddr_o,
    output logic               wEn_o,
    output logic               outBuf_o
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr;
    logic               mem_we;
    decode_t            dec;

    // Program loads are only accepted while idle so a running program never changes under us.
    assign mem_we = prog_we_i && (state_q == S_IDLE);

    dp_seq_prog_mem u_prog_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .raddr_i (pc_q),
        .rdata_o (instr)
    );

    assign dec = decode_instr(instr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        busy_o   = (state_q != S_IDLE);
        done_o   = 1'b0;
        MuxSel_o = 1'b0;
        wEn_o    = 1'b0;
        outBuf_o = 1'b0;
        raddr1_o = '0;
        raddr2_o = '0;
        waddr_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end

            S_FETCH: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (!step_mode_i || step_i) begin
                    state_d = S_EXEC;
                end
`else
                state_d = S_EXEC;
`endif
            end

            S_EXEC: begin
                waddr_o  = dec.waddr;
                raddr1_o = dec.raddr1;
                raddr2_o = dec.raddr2;
                pc_d     = pc_q + PC_W'(1);
                state_d  = S_FETCH;
                case (dec.op)
                    OP_ALU: begin
                        wEn_o = 1'b1;
                    end
                    OP_MOVK: begin
                        wEn_o    = 1'b1;
                        MuxSel_o = 1'b1;
                    end
                    OP_OUT: begin
                        outBuf_o = 1'b1;
                    end
                    OP_BLE: begin
                        if (le_i) begin
                            pc_d = dec.target;
                        end
                    end
                    OP_JMP: begin
                        pc_d = dec.target;
                    end
                    OP_HALT: begin
                        done_o  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                    end
                endcase
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dp_microsequencer.sv
// Self-checking bench for dp_microsequencer: expected cycle traces come from an instruction-level program model.
module tb_dp_microsequencer;
    import dp_seq_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic               busy_o;
    logic               done_o;
    logic               prog_we_i;
    logic [PC_W-1:0]    prog_addr_i;
    logic [INSTR_W-1:0] prog_data_i;
    logic               le_i;
    logic               MuxSel_o;
    logic [3:0]         raddr1_o;
    logic [3:0]         raddr2_o;
    logic [3:0]         waddr_o;
    logic               wEn_o;
    logic               outBuf_o;

    int total = 0;
    int bad   = 0;

    logic [INSTR_W-1:0] modelMem [PROG_DEPTH];
    logic [16:0]        expQ [$];
    logic               leQ [$];
    bit                 traceHalted;

    wire [16:0] obsVec = {busy_o, done_o, MuxSel_o, wEn_o, outBuf_o, waddr_o, raddr1_o, raddr2_o};

    always #5 clk_i = ~clk_i;

    dp_microsequencer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .prog_we_i   (prog_we_i),
        .prog_addr_i (prog_addr_i),
        .prog_data_i (prog_data_i),
        .le_i        (le_i),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode_i (1'b0),
        .step_i      (1'b0),
`endif
        .MuxSel_o    (MuxSel_o),
        .raddr1_o    (raddr1_o),
        .raddr2_o    (raddr2_o),
        .waddr_o     (waddr_o),
        .wEn_o       (wEn_o),
        .outBuf_o    (outBuf_o)
    );

    function automatic logic [INSTR_W-1:0] mk(input int op, input int w, input int a, input int b, input int t);
        return {op[3:0], w[3:0], a[3:0], b[3:0], t[PC_W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [INSTR_W-1:0] data);
        prog_we_i   = 1'b1;
        prog_addr_i = addr[PC_W-1:0];
        prog_data_i = data;
        modelMem[addr[PC_W-1:0]] = data;
        tick();
        prog_we_i = 1'b0;
    endtask

    // Instruction-level program model: every instruction costs a fetch cycle then an execute cycle.
    // leMode: 0 = le low, 1 = le high, 2 = random, 3 = alternate high/low per BLE.
    task automatic build_trace(input int maxInstr, input int leMode);
        int pc = 0;
        int bleCount = 0;
        logic [INSTR_W-1:0] w;
        logic [3:0] op, wa, a, b;
        int t;
        logic leVal;
        logic [16:0] e;
        expQ.delete();
        leQ.delete();
        traceHalted = 0;
        for (int i = 0; i < maxInstr; i++) begin
            w  = modelMem[pc[PC_W-1:0]];
            op = w[INSTR_W-1 -: 4];
            wa = w[INSTR_W-5 -: 4];
            a  = w[INSTR_W-9 -: 4];
            b  = w[INSTR_W-13 -: 4];
            t  = int'(w[PC_W-1:0]);
            if (op == 4'h4) begin
                case (leMode)
                    0: leVal = 1'b0;
                    1: leVal = 1'b1;
                    3: leVal = ((bleCount % 2) == 0);
                    default: leVal = 1'($urandom % 2);
                endcase
                bleCount++;
            end else begin
                leVal = 1'($urandom % 2);
            end
            expQ.push_back(17'h10000);
            leQ.push_back(1'($urandom % 2));
            e = {1'b1, (op == 4'hF), (op == 4'h2), (op == 4'h1 || op == 4'h2), (op == 4'h3), wa, a, b};
            expQ.push_back(e);
            leQ.push_back(leVal);
            if (op == 4'hF) begin
                expQ.push_back(17'h0);
                leQ.push_back(1'b0);
                traceHalted = 1;
                break;
            end else if (op == 4'h5 || (op == 4'h4 && leVal)) begin
                pc = t;
            end else begin
                pc = (pc + 1) % PROG_DEPTH;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obsVec !== 17'h0) begin
                bad++;
                $display("FAIL reset cyc%0d got=%h want=%h", i, obsVec, 17'h0);
            end
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_alu_halt();
        int c = 0;
        int doneCycle = -1;
        logic [16:0] e;
        load_word(0, mk(1, 3, 1, 2, 0));
        load_word(1, mk(15, 0, 0, 0, 0));
        build_trace(8, 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (expQ.size() > 0) begin
            c++;
            le_i = leQ.pop_front();
            e = expQ.pop_front();
            if (done_o === 1'b1) doneCycle = c;
            total++;
            if (obsVec !== e) begin
                bad++;
                $display("FAIL alu_halt cyc%0d got=%h want=%h", c, obsVec, e);
            end
            if (c == 5) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL alu_halt_busy_drop got=%b want=0", busy_o);
                end
            end
            tick();
        end
        total++;
        if (doneCycle != 4) begin
            bad++;
            $display("FAIL alu_halt_done_cycle got=%0d want=4", doneCycle);
        end
    endtask

    task automatic test_ble();
        int c;
        logic [16:0] e;
        logic [3:0] r1;
        load_word(0, mk(4, 0, 1, 2, 5));
        load_word(1, mk(3, 0, 1, 0, 0));
        load_word(2, mk(15, 0, 0, 0, 0));
        load_word(5, mk(3, 0, 5, 0, 0));
        load_word(6, mk(15, 0, 0, 0, 0));
        for (int pass = 0; pass < 2; pass++) begin
            build_trace(10, (pass == 0) ? 1 : 0);
            c = 0;
            r1 = 4'hX;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            while (expQ.size() > 0) begin
                c++;
                le_i = leQ.pop_front();
                e = expQ.pop_front();
                if (c == 2) le_i = (pass == 0);
                if (c == 4) r1 = raddr1_o;
                total++;
                if (obsVec !== e) begin
                    bad++;
                    $display("FAIL ble_le%0d cyc%0d got=%h want=%h", 1 - pass, c, obsVec, e);
                end
                tick();
            end
            total++;
            if (r1 !== ((pass == 0) ? 4'd5 : 4'd1)) begin
                bad++;
                $display("FAIL ble_target_le%0d got=%h want=%h", 1 - pass, r1, (pass == 0) ? 4'd5 : 4'd1);
            end
        end
    endtask

    task automatic test_wrap();
        int c = 0;
        logic [16:0] e;
        load_word(0, mk(4, 0, 0, 0, 14));
        load_word(1, mk(15, 0, 0, 0, 0));
        load_word(14, mk(0, 1, 14, 2, 0));
        load_word(15, mk(0, 3, 15, 4, 0));
        build_trace(12, 3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (expQ.size() > 0) begin
            c++;
            le_i = leQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (obsVec !== e) begin
                bad++;
                $display("FAIL wrap cyc%0d got=%h want=%h", c, obsVec, e);
            end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        int c;
        logic [16:0] e;
        load_word(0, mk(1, 1, 2, 3, 0));
        load_word(1, mk(3, 0, 9, 0, 0));
        load_word(2, mk(15, 0, 0, 0, 0));
        for (int pass = 0; pass < 2; pass++) begin
            build_trace(8, 2);
            c = 0;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            while (expQ.size() > 0) begin
                c++;
                le_i = leQ.pop_front();
                e = expQ.pop_front();
                total++;
                if (obsVec !== e) begin
                    bad++;
                    $display("FAIL busy_ignore_p%0d cyc%0d got=%h want=%h", pass, c, obsVec, e);
                end
                prog_we_i   = (pass == 0 && c == 2);
                prog_addr_i = PC_W'(1);
                prog_data_i = INSTR_W'(32'h30);
                start_i     = (pass == 0 && c == 3);
                tick();
            end
            prog_we_i = 1'b0;
            start_i   = 1'b0;
        end
    endtask

    task automatic test_write_start();
        int c = 0;
        logic [16:0] e;
        load_word(1, mk(15, 0, 0, 0, 0));
        prog_we_i   = 1'b1;
        prog_addr_i = '0;
        prog_data_i = mk(3, 0, 6, 0, 0);
        modelMem[0] = mk(3, 0, 6, 0, 0);
        start_i     = 1'b1;
        build_trace(8, 2);
        tick();
        prog_we_i = 1'b0;
        start_i   = 1'b0;
        while (expQ.size() > 0) begin
            c++;
            le_i = leQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (obsVec !== e) begin
                bad++;
                $display("FAIL write_start cyc%0d got=%h want=%h", c, obsVec, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_midexec();
        int c = 0;
        logic [16:0] e;
        load_word(0, mk(2, 7, 4, 5, 0));
        load_word(1, mk(15, 0, 0, 0, 0));
        build_trace(8, 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            le_i = leQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (obsVec !== e) begin
                bad++;
                $display("FAIL rst_mid_pre cyc%0d got=%h want=%h", i, obsVec, e);
            end
            if (i == 2) rst_i = 1'b1;
            tick();
        end
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obsVec !== 17'h0) begin
                bad++;
                $display("FAIL rst_mid_after cyc%0d got=%h want=%h", i, obsVec, 17'h0);
            end
            tick();
        end
        build_trace(8, 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (expQ.size() > 0) begin
            c++;
            le_i = leQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (obsVec !== e) begin
                bad++;
                $display("FAIL rst_mid_rerun cyc%0d got=%h want=%h", c, obsVec, e);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int opList [9] = '{0, 1, 2, 3, 4, 5, 15, 7, 9};
        int c;
        logic [16:0] e;
        for (int iter = 0; iter < 6; iter++) begin
            for (int a = 0; a < PROG_DEPTH; a++) begin
                load_word(a, mk(opList[$urandom_range(8, 0)], int'($urandom), int'($urandom),
                                int'($urandom), int'($urandom)));
            end
            build_trace(25, 2);
            c = 0;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            while (expQ.size() > 0) begin
                c++;
                le_i = leQ.pop_front();
                e = expQ.pop_front();
                total++;
                if (obsVec !== e) begin
                    bad++;
                    $display("FAIL random_it%0d cyc%0d got=%h want=%h", iter, c, obsVec, e);
                end
                tick();
            end
            if (!traceHalted) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                total++;
                if (obsVec !== 17'h0) begin
                    bad++;
                    $display("FAIL random_abort_it%0d got=%h want=%h", iter, obsVec, 17'h0);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        prog_we_i   = 1'b0;
        prog_addr_i = '0;
        prog_data_i = '0;
        le_i        = 1'b0;
        for (int i = 0; i < PROG_DEPTH; i++) modelMem[i] = '0;
        test_reset();
        test_alu_halt();
        test_ble();
        test_wrap();
        test_busy_ignore();
        test_write_start();
        test_reset_midexec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
